conv_result_uart_tx: RTL and testbench
======================================

// Module: conv_result_uart_tx
// PURPOSE
//  Downstream stage of the convolution engine. When conv_done rises, reads the
//  (N-P+1)^2 convolved pixels from the result BRAM, addresses 0..M*M-1 with M=N-P+1.
//  Streams each pixel out over a UART 8N1 line, LSB first, to the host PC.
//  Shares the result BRAM through a read-only port; the convolution engine owns the write port.
// PARAMETERS
//  N            20   input image side (pixels)
//  P            3    filter side; result side M = N-P+1
//  ADDR_W       14   result BRAM address width
//  CLKS_PER_BIT 868  clk cycles per UART bit (100 MHz / 115200)
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  conv_done  in   1       level from convolution engine; rising edge starts a frame
//  ena_res    out  1       result BRAM port enable (read port, wea tied 0 outside)
//  addr_res   out  ADDR_W  result BRAM read address
//  dout_res   in   8       result BRAM read data, valid 1 clk after addr/ena
//  tx         out  1       UART serial line, idle high
//  tx_busy    out  1       high from first FETCH until end of last stop bit
//  tx_done    out  1       high after the full frame is sent; cleared by rst or new start
//  byte_cnt   out  ADDR_W  index of the byte currently being sent
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, any state): tx=1, tx_busy=0, tx_done=0, ena_res=0,
//   addr_res=0, byte_cnt=0, state=IDLE, conv_done edge register cleared.
//  Reset mid-byte aborts immediately: tx is forced high on the next edge, with no stop-bit completion.
//  Start: conv_done is registered each clk as cd_q. start = conv_done & ~cd_q.
//   Only a rising edge starts a frame; a held-high level never retriggers.
//  FSM states: IDLE, FETCH, WAIT, START, DATA, STOP, DONE.
//   IDLE:  tx=1. On start: byte_cnt<=0, tx_done<=0, go FETCH.
//   FETCH: 1 clk. ena_res=1, addr_res=byte_cnt. go WAIT.
//   WAIT:  1 clk. Latch dout_res into shift register sh. go START.
//   START: tx=0 for CLKS_PER_BIT clks.
//   DATA:  tx=sh[0] for CLKS_PER_BIT clks per bit. Shift right after each bit.
//          Run 8 bits, counted by a 3-bit counter, then go STOP.
//   STOP:  tx=1 for CLKS_PER_BIT clks. Then:
//          if byte_cnt==M*M-1, go DONE;
//          otherwise byte_cnt<=byte_cnt+1 and go FETCH.
//   DONE:  tx=1, tx_busy=0, tx_done=1. On start, clear tx_done, byte_cnt<=0, go FETCH.
//  ena_res is high only in FETCH and WAIT. addr_res holds its last value otherwise.
//  Timing: each byte takes exactly 2+10*CLKS_PER_BIT clks, with no gap between bytes.
//   The first FETCH is the clk after the edge where start is seen.
//   The frame takes M*M*(2+10*CLKS_PER_BIT) clks.
//  Bit timer: ceil(log2(CLKS_PER_BIT)) bits wide, reloaded to 0 at every bit boundary.
//  A conv_done fall or re-rise during a frame (busy) is ignored; the frame always completes.
//  tx is registered (glitch-free) and driven from the FSM, not combinationally from the BRAM.
// TESTING
//  1 N=5,P=3,CPB=4, BRAM[i]=i+1 (i=0..8), pulse conv_done -> 9 frames decode to 01..09 LSB-first,
//    tx_done rises 378 clks after the first FETCH, and tx_busy is high for exactly those clks.
//  2 Hold conv_done high for 1000 clks after the frame -> exactly one frame; after DONE, tx stays 1.
//  3 BRAM pattern 0x00 and 0xFF alternating -> start bit 0 and stop bit 1 are present on every byte;
//    each bit lasts exactly 4 clks.
//  4 Assert rst during data bit 3 of byte 2 -> the next clk has tx=1, busy=0, addr_res=0.
//    A new conv_done rise then restarts the frame from address 0.
//  5 Toggle conv_done 0->1->0->1 mid-frame -> the frame is unaffected (9 bytes).
//    A rise after DONE starts a second identical frame, and tx_done clears on that start.
//  6 Default params (N=20,P=3,CPB=868) -> byte_cnt ends at 323, and addr_res never exceeds 323.

Source files
------------

// File: rtl/conv_result_uart_tx_if.sv
// rtl/conv_result_uart_tx_if.sv - result-BRAM read port, frame trigger and UART status bundle
// master is the transmitter side; slave is the convolution engine / BRAM / host side.
interface conv_result_uart_tx_if #(
   parameter int ADDR_W = 14
);
   logic              conv_done;
   logic              ena_res;
   logic [ADDR_W-1:0] addr_res;
   logic [7:0]        dout_res;
   logic              tx;
   logic              tx_busy;
   logic              tx_done;
   logic [ADDR_W-1:0] byte_cnt;

   modport master (
      input  conv_done, dout_res,
      output ena_res, addr_res, tx, tx_busy, tx_done, byte_cnt
   );

   modport slave (
      output conv_done, dout_res,
      input  ena_res, addr_res, tx, tx_busy, tx_done, byte_cnt
   );
endinterface

// File: rtl/conv_result_uart_tx.sv
// rtl/conv_result_uart_tx.sv - streams the M*M convolution result BRAM to the host over UART 8N1
// Each byte is FETCH, WAIT, START, 8 DATA bits and STOP with no idle gap between bytes.
module conv_result_uart_tx #(
   parameter int N            = 20,
   parameter int P            = 3,
   parameter int ADDR_W       = 14,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   conv_result_uart_tx_if.master bus
);
   localparam int                M         = N - P + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(M * M - 1);
   localparam int                TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0]     TMR_LAST  = TW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_STOP  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]        state_q, state_d;
   logic              cd_q;
   logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ena_q, ena_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [7:0]        sh_q, sh_d;
   logic [2:0]        bit_q, bit_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              start;
   logic              tmr_end;

   always_comb begin
      start      = bus.conv_done & ~cd_q;
      tmr_end    = (tmr_q == TMR_LAST);
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      busy_d     = busy_q;
      done_d     = done_q;
      sh_d       = sh_q;
      bit_d      = bit_q;
      tmr_d      = tmr_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_FETCH;
               byte_cnt_d = '0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
            end
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            sh_d    = bus.dout_res;
            tmr_d   = '0;
            state_d = S_START;
         end
         S_START: begin
            if (tmr_end) begin
               tmr_d   = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_DATA: begin
            if (tmr_end) begin
               tmr_d = '0;
               sh_d  = {1'b0, sh_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_STOP: begin
            if (tmr_end) begin
               tmr_d = '0;
               if (byte_cnt_q == LAST_ADDR) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  state_d    = S_FETCH;
               end
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so tx never glitches off BRAM data.
      ena_d  = (state_d == S_FETCH) || (state_d == S_WAIT);
      addr_d = (state_d == S_FETCH) ? byte_cnt_d : addr_q;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = sh_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         cd_q       <= 1'b0;
         byte_cnt_q <= '0;
         addr_q     <= '0;
         ena_q      <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sh_q       <= '0;
         bit_q      <= '0;
         tmr_q      <= '0;
      end else begin
         state_q    <= state_d;
         cd_q       <= bus.conv_done;
         byte_cnt_q <= byte_cnt_d;
         addr_q     <= addr_d;
         ena_q      <= ena_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         sh_q       <= sh_d;
         bit_q      <= bit_d;
         tmr_q      <= tmr_d;
      end
   end

   assign bus.ena_res  = ena_q;
   assign bus.addr_res = addr_q;
   assign bus.tx       = tx_q;
   assign bus.tx_busy  = busy_q;
   assign bus.tx_done  = done_q;
   assign bus.byte_cnt = byte_cnt_q;
endmodule

// File: tb/tb_conv_result_uart_tx.sv
// tb/tb_conv_result_uart_tx.sv - scoreboard bench: UART decoder pops expected bytes per frame
// A second instance with default image size and one clk per bit covers the full address range.
module tb_conv_result_uart_tx;
   localparam int CPB       = 4;
   localparam int NB        = 9;
   localparam int AW        = 14;
   localparam int BYTE_CLKS = 2 + 10 * CPB;
   localparam int FRAME     = NB * BYTE_CLKS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_result_uart_tx_if #(.ADDR_W(AW)) sif ();
   conv_result_uart_tx_if #(.ADDR_W(AW)) bif ();

   conv_result_uart_tx #(.N(5), .P(3), .ADDR_W(AW), .CLKS_PER_BIT(CPB)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (sif)
   );

   conv_result_uart_tx #(.N(20), .P(3), .ADDR_W(AW), .CLKS_PER_BIT(1)) u_big (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bif)
   );

   logic [7:0] mem [16];
   always @(posedge clk) if (sif.ena_res) sif.dout_res <= mem[sif.addr_res[3:0]];
   always @(posedge clk) if (bif.ena_res) bif.dout_res <= bif.addr_res[7:0];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART receiver: start edge at tick 0, samples at tick 1 of each CPB-wide slot.
   logic [7:0] exp_q[$];
   int         dec_tick, dec_slot, rx_count = 0;
   bit         dec_active = 0, dec_start_ok, dec_stop_ok, dec_edge_ok;
   logic [7:0] dec_byte;
   logic       prev_tx = 1'b1;

   always @(negedge clk) begin
      if (rst) begin
         dec_active = 0;
         prev_tx    = 1'b1;
      end else begin
         if (!dec_active) begin
            if (prev_tx === 1'b1 && sif.tx === 1'b0) begin
               dec_active = 1; dec_tick = 0; dec_byte = '0;
               dec_edge_ok = 1; dec_start_ok = 0; dec_stop_ok = 0;
            end
         end else begin
            dec_tick++;
            if (dec_tick % CPB != 0 && sif.tx !== prev_tx) dec_edge_ok = 0;
         end
         if (dec_active && dec_tick % CPB == 1) begin
            dec_slot = dec_tick / CPB;
            if (dec_slot == 0)      dec_start_ok = (sif.tx === 1'b0);
            else if (dec_slot <= 8) dec_byte[dec_slot-1] = sif.tx;
            else                    dec_stop_ok = (sif.tx === 1'b1);
         end
         if (dec_active && dec_tick == 10 * CPB - 1) begin
            check("start_bit", dec_start_ok, 1);
            check("stop_bit", dec_stop_ok, 1);
            check("bit_width", dec_edge_ok, 1);
            check("byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("rx_byte", dec_byte, exp_q.pop_front());
            rx_count++;
            dec_active = 0;
         end
         prev_tx = sif.tx;
      end
   end

   task automatic expect_frame();
      for (int i = 0; i < NB; i++) exp_q.push_back(mem[i]);
   endtask

   task automatic rise();
      sif.conv_done = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_frame(output int lat, output int bn);
      lat = 0;
      bn  = 0;
      while (sif.tx_done !== 1'b1 && lat < 4 * FRAME) begin
         if (sif.tx_busy === 1'b1) bn++;
         lat++;
         @(negedge clk);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat, bn, bad, rx0, maxa;
      sif.conv_done = 1'b0;
      bif.conv_done = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = (i < NB) ? 8'(i + 1) : 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx", sif.tx, 1);
      check("rst_busy", sif.tx_busy, 0);
      check("rst_done", sif.tx_done, 0);
      check("rst_ena", sif.ena_res, 0);
      check("rst_addr", sif.addr_res, 0);
      check("rst_byte_cnt", sif.byte_cnt, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single-cycle pulse: frame of 01..09, fetch one clk after the edge.
      expect_frame();
      rise();
      check("fetch_busy", sif.tx_busy, 1);
      check("fetch_ena", sif.ena_res, 1);
      check("fetch_addr", sif.addr_res, 0);
      sif.conv_done = 1'b0;
      wait_frame(lat, bn);
      check("frame_latency", lat, FRAME);
      check("busy_cycles", bn, FRAME);
      check("final_byte_cnt", sif.byte_cnt, NB - 1);
      check("final_addr_hold", sif.addr_res, NB - 1);
      check("done_ena", sif.ena_res, 0);
      check("frame1_all_rx", exp_q.size(), 0);

      // Held-high level: exactly one frame, then idle line.
      expect_frame();
      rise();
      check("done_clear_on_start", sif.tx_done, 0);
      wait_frame(lat, bn);
      check("held_frame_latency", lat, FRAME);
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (sif.tx_busy !== 1'b0 || sif.tx !== 1'b1 || sif.tx_done !== 1'b1) bad++;
      end
      check("held_no_retrigger", bad, 0);
      check("held_all_rx", exp_q.size(), 0);

      // Re-rise after DONE plus conv_done toggling mid-frame.
      sif.conv_done = 1'b0;
      @(negedge clk);
      rx0 = rx_count;
      expect_frame();
      rise();
      check("restart_done_clear", sif.tx_done, 0);
      repeat (40) @(negedge clk);
      sif.conv_done = 1'b0; @(negedge clk);
      sif.conv_done = 1'b1; @(negedge clk);
      sif.conv_done = 1'b0; @(negedge clk);
      sif.conv_done = 1'b1;
      wait_frame(lat, bn);
      check("toggle_frame_latency", lat + 43, FRAME);
      check("toggle_rx_count", rx_count - rx0, NB);
      check("toggle_all_rx", exp_q.size(), 0);

      // Alternating 00/FF: framing bits and bit width on every byte.
      for (int i = 0; i < NB; i++) mem[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
      sif.conv_done = 1'b0;
      @(negedge clk);
      expect_frame();
      rise();
      sif.conv_done = 1'b0;
      wait_frame(lat, bn);
      check("alt_frame_latency", lat, FRAME);
      check("alt_all_rx", exp_q.size(), 0);

      // Reset during data bit 3 of byte 2, then restart from address 0.
      for (int i = 0; i < NB; i++) mem[i] = 8'(i + 1);
      exp_q.push_back(mem[0]);
      exp_q.push_back(mem[1]);
      rise();
      sif.conv_done = 1'b0;
      repeat (2 * BYTE_CLKS + 2 + CPB + 3 * CPB + 1) @(negedge clk);
      check("abort_point_byte", sif.byte_cnt, 2);
      rst = 1'b1;
      @(negedge clk);
      check("abort_tx", sif.tx, 1);
      check("abort_busy", sif.tx_busy, 0);
      check("abort_addr", sif.addr_res, 0);
      check("abort_ena", sif.ena_res, 0);
      check("abort_byte_cnt", sif.byte_cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_prior_rx", exp_q.size(), 0);
      expect_frame();
      rise();
      check("restart_addr", sif.addr_res, 0);
      check("restart_ena", sif.ena_res, 1);
      sif.conv_done = 1'b0;
      wait_frame(lat, bn);
      check("restart_latency", lat, FRAME);
      check("restart_all_rx", exp_q.size(), 0);

      // Default image size: 18x18 results, addresses 0..323.
      bif.conv_done = 1'b1;
      @(negedge clk);
      lat = 0;
      maxa = 0;
      while (bif.tx_done !== 1'b1 && lat < 10000) begin
         if (bif.ena_res === 1'b1 && int'(bif.addr_res) > maxa) maxa = int'(bif.addr_res);
         lat++;
         @(negedge clk);
      end
      check("big_latency", lat, 324 * 12);
      check("big_byte_cnt", bif.byte_cnt, 323);
      check("big_max_addr", maxa, 323);
      check("big_tx_idle", bif.tx, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
